regfile_wb_arbiter: RTL and testbench
=====================================

# regfile_wb_arbiter

Shares the register file's single write port between two writeback sources: the ALU result path and the memory load path. It accepts requests with valid/ready handshakes, picks one winner per cycle, and registers the winner onto the write port. It also exposes that registered stage as a forwarding source. It sits between the execute/memory stages and the register file.

## Interface
Parameters:
- ADDR_W, 5, register address width (32 registers)
- DATA_W, 32, register data width

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset, synchronous, active-high
- alu_valid  in  1  ALU writeback request
- alu_addr  in  ADDR_W  ALU destination register
- alu_data  in  DATA_W  ALU result
- alu_ready  out  1  ALU request accepted this cycle
- mem_valid  in  1  load writeback request
- mem_addr  in  ADDR_W  load destination register
- mem_data  in  DATA_W  load data
- mem_ready  out  1  load request accepted this cycle
- we  out  1  register file write enable (registered)
- addr_write  out  ADDR_W  register file write address (registered)
- data_write  out  DATA_W  register file write data (registered)
- fwd_src  out  1  source of the current write stage: 0=ALU, 1=MEM; valid when we=1

## Operation
- Handshake: a transfer occurs when x_valid && x_ready.
- At most one ready is high per cycle. Ready is combinational from the valids and the arbitration state, and never depends on itself.
- The register file always accepts a write, so the output stage never stalls. The granted request reaches we/addr_write/data_write on the next posedge.
- Writes to address 0:
  - The handshake completes normally (ready=1).
  - The output stage loads we=0, so r0 is never written.
- Arbitration when only one source is valid: that source is granted.
- Arbitration when both are valid:
  - If mem_addr == alu_addr and the address is nonzero, MEM is granted. This is the ordering rule: the load is older, so the younger ALU write lands last.
  - Otherwise the round-robin pointer decides (see Configuration).
- Round-robin pointer: updates only on a granted transfer, to point at the non-granted source.
- An unaccepted request must hold valid, addr and data stable until it is accepted. The bench checks this; the RTL does not.
- Registered state:
  - output stage: we, addr_write, data_write, fwd_src
  - pointer: last_grant

## Timing
- Reset values:
  - we=0, addr_write=0, data_write=0, fwd_src=0
  - last_grant=ALU, so MEM is preferred first
  - alu_ready=0 and mem_ready=0 while rst=1
- Reset mid-operation: any in-flight output stage is discarded and we=0 on the next cycle. Pending requests are not accepted while rst=1.
- Latency: exactly 1 cycle from handshake to we=1 (0 if the address is 0).
- Throughput: 1 write per cycle.
- Starvation bound (RR build): a continuously valid source is granted within 2 cycles.
- Idle (no valid): next cycle we=0; addr_write and data_write hold their previous values.

## Configuration
- WBARB_RR_EN defined:
  - round-robin between ALU and MEM on conflict, using last_grant
  - the same-address rule still overrides the pointer
- WBARB_RR_EN undefined:
  - fixed priority, MEM over ALU
  - last_grant register and its logic are removed
  - ALU may starve while MEM is continuously valid

## Structure
- Shared package regfile_pkg holds:
  - REG_ADDR_W=5, REG_DATA_W=32, NUM_REGS=32
  - ZERO_REG=5'd0
  - typedef wb_src_t: SRC_ALU=0, SRC_MEM=1
- One sub-module, rr_arb2:
  - 2-way arbiter containing the pointer register
  - inputs: req[1:0], force_mem
  - output: gnt[1:0]
  - compiled as fixed priority when WBARB_RR_EN is undefined
- The top level holds the ready decode, zero-address suppression and output stage.

## Test plan
- Reset: hold rst 3 cycles with both valid. Expect both ready=0 and we=0. After release, with both valid to different addresses, MEM is granted first.
- Single source: alu_valid, addr 5, data 0xDEADBEEF. Expect alu_ready=1 that cycle, and we=1, addr_write=5, data_write=0xDEADBEEF, fwd_src=0 one cycle later.
- Conflict, RR build: both valid continuously (ALU addr 3, MEM addr 4, with fresh data each accept).
  - Expect grants alternating MEM, ALU, MEM, …
  - Expect writes to 4, 3, 4, … on consecutive cycles.
- Same-address conflict: both valid to addr 7 (MEM 0x1111, ALU 0x2222), with the pointer favouring ALU. Expect write 0x1111 then 0x2222 to r7, so r7 ends at 0x2222.
- Zero address: mem_valid, addr 0, data 0xFFFFFFFF. Expect mem_ready=1 and we=0 next cycle. A subsequent read of r0 must be unaffected.
- Reset mid-operation: assert rst in the cycle after a handshake. Expect we=0 on the next edge, and no write reaches the register file after rst.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared register-file widths, the zero-register address and writeback source encoding.
package regfile_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam int NUM_REGS   = 32;
    localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;
    typedef enum logic {SRC_ALU = 1'b0, SRC_MEM = 1'b1} wb_src_t;
endpackage

// File: rtl/regfile_wb_arbiter_rr_arb2.sv
// rr_arb2: two-way writeback arbiter, req[0]=ALU, req[1]=MEM.
// Round-robin with a last_grant pointer under WBARB_RR_EN, otherwise fixed MEM-over-ALU priority.
module rr_arb2
    import regfile_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       force_mem,
    output logic [1:0] gnt
);
`ifdef WBARB_RR_EN
    wb_src_t last_grant;
    always_comb begin
        gnt = (req == 2'b11) ? ((force_mem || last_grant == SRC_ALU) ? 2'b10 : 2'b01) : req;
    end
    always_ff @(posedge clk) begin
        if (rst) last_grant <= SRC_ALU;
        else if (|gnt) last_grant <= gnt[1] ? SRC_MEM : SRC_ALU;
    end
`else
    // MEM always wins, so the same-address ordering holds without the pointer
    logic unused_ok;
    assign unused_ok = ^{clk, rst, force_mem};
    assign gnt = {req[1], req[0] & ~req[1]};
`endif
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register file write port between ALU and load writeback.
// Build option WBARB_RR_EN selects round-robin arbitration instead of fixed MEM priority.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int ADDR_W = REG_ADDR_W,
    parameter int DATA_W = REG_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_addr,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_ready,
    input  logic              mem_valid,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    output logic              mem_ready,
    output logic              we,
    output logic [ADDR_W-1:0] addr_write,
    output logic [DATA_W-1:0] data_write,
    output logic              fwd_src
);
    logic [1:0]        gnt;
    logic              force_mem;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    // older load must land before the younger ALU write to the same register
    assign force_mem = alu_valid && mem_valid && alu_addr == mem_addr && mem_addr != ADDR_W'(ZERO_REG);

    rr_arb2 u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       ({mem_valid, alu_valid} & {2{~rst}}),
        .force_mem (force_mem),
        .gnt       (gnt)
    );

    assign alu_ready = gnt[0];
    assign mem_ready = gnt[1];
    assign sel_addr  = gnt[1] ? mem_addr : alu_addr;
    assign sel_data  = gnt[1] ? mem_data : alu_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            we         <= 1'b0;
            addr_write <= '0;
            data_write <= '0;
            fwd_src    <= SRC_ALU;
        end else begin
            we <= |gnt && sel_addr != ADDR_W'(ZERO_REG);
            if (|gnt) begin
                addr_write <= sel_addr;
                data_write <= sel_data;
                fwd_src    <= gnt[1];
            end
        end
    end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed checks of handshake, arbitration, zero-register and reset behaviour.
module tb_regfile_wb_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid, mem_valid, alu_ready, mem_ready;
    logic [4:0]  alu_addr, mem_addr, addr_write;
    logic [31:0] alu_data, mem_data, data_write;
    logic        we, fwd_src;
    logic [31:0] regs [32] = '{default: 32'h0};
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    // reference register file: writes whatever the write port presents
    always @(posedge clk) if (we) regs[addr_write] <= data_write;

    regfile_wb_arbiter dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ready(mem_ready),
        .we(we), .addr_write(addr_write), .data_write(data_write), .fwd_src(fwd_src)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_wr(input string tag, input logic [4:0] a, input logic [31:0] d, input logic src);
        check({tag, ".we"}, we, 1);
        check({tag, ".addr"}, addr_write, a);
        check({tag, ".data"}, data_write, d);
        check({tag, ".src"}, fwd_src, src);
    endtask

    initial begin
        logic        exp_mem;
        logic [31:0] ad, md;
        rst = 1; alu_valid = 1; alu_addr = 1; alu_data = 32'hAAAA0001;
        mem_valid = 1; mem_addr = 2; mem_data = 32'hBBBB0002;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("rst.alu_ready", alu_ready, 0);
            check("rst.mem_ready", mem_ready, 0);
            step();
            check("rst.we", we, 0);
        end
        check("rst.addr", addr_write, 0);
        check("rst.data", data_write, 0);
        check("rst.src", fwd_src, 0);
        rst = 0; #1;
        check("first.mem_ready", mem_ready, 1);
        check("first.alu_ready", alu_ready, 0);
        step();
        check_wr("first", 2, 32'hBBBB0002, 1);
        mem_valid = 0; #1;
        check("second.alu_ready", alu_ready, 1);
        step();
        check_wr("second", 1, 32'hAAAA0001, 0);
        alu_valid = 0;
        step();
        check("idle.we", we, 0);
        check("idle.addr", addr_write, 1);
        check("idle.data", data_write, 32'hAAAA0001);

        alu_valid = 1; alu_addr = 5; alu_data = 32'hDEADBEEF; #1;
        check("single.alu_ready", alu_ready, 1);
        check("single.mem_ready", mem_ready, 0);
        step();
        check_wr("single", 5, 32'hDEADBEEF, 0);

        // conflict with distinct addresses; pointer last granted ALU
        ad = 32'hA000_0000; md = 32'hB000_0000;
        alu_addr = 3; mem_addr = 4; alu_data = ad; mem_data = md;
        alu_valid = 1; mem_valid = 1;
        for (int i = 0; i < 4; i++) begin
`ifdef WBARB_RR_EN
            exp_mem = (i % 2 == 0);
`else
            exp_mem = 1'b1;
`endif
            #1;
            check("rr.mem_ready", mem_ready, exp_mem);
            check("rr.alu_ready", alu_ready, !exp_mem);
            step();
            check_wr("rr", exp_mem ? 5'd4 : 5'd3, exp_mem ? md : ad, exp_mem);
            if (exp_mem) md++; else ad++;
            alu_data = ad; mem_data = md;
        end
        alu_valid = 0;
        // MEM-only write leaves the pointer favouring ALU
        mem_addr = 9; mem_data = 32'h99; #1;
        check("pre.mem_ready", mem_ready, 1);
        step();
        check_wr("pre", 9, 32'h99, 1);

        alu_valid = 1; alu_addr = 7; alu_data = 32'h2222;
        mem_valid = 1; mem_addr = 7; mem_data = 32'h1111; #1;
        check("same.mem_ready", mem_ready, 1);
        check("same.alu_ready", alu_ready, 0);
        step();
        check_wr("same1", 7, 32'h1111, 1);
        mem_valid = 0; #1;
        check("same.alu_ready2", alu_ready, 1);
        step();
        check_wr("same2", 7, 32'h2222, 0);
        alu_valid = 0;
        step();
        check("same.idle_we", we, 0);
        check("same.r7", regs[7], 32'h2222);
        check("same.r9", regs[9], 32'h99);

        mem_valid = 1; mem_addr = 0; mem_data = 32'hFFFFFFFF; #1;
        check("zero.mem_ready", mem_ready, 1);
        step();
        check("zero.we", we, 0);
        mem_valid = 0;
        step();
        check("zero.r0", regs[0], 0);

        alu_valid = 1; alu_addr = 10; alu_data = 32'h5555; #1;
        check("mid.alu_ready", alu_ready, 1);
        step();
        check_wr("mid", 10, 32'h5555, 0);
        rst = 1; alu_valid = 0;
        mem_valid = 1; mem_addr = 11; mem_data = 32'h6666; #1;
        check("mid.rst_mem_ready", mem_ready, 0);
        step();
        check("mid.rst_we", we, 0);
        check("mid.rst_mem_ready2", mem_ready, 0);
        step();
        check("mid.rst_we2", we, 0);
        rst = 0; mem_valid = 0;
        step();
        check("mid.after_we", we, 0);
        check("mid.r11", regs[11], 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
